// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared types, defaults and width helper for the pattern scan controller
package pattern_scan_pkg;

  // Default geometry of the scanner
  localparam int WORD_W_DEF  = 8;
  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

  // Width needed to hold a pattern length in the range 0..pat_max
  function automatic int len_w(input int pat_max);
    return $clog2(pat_max + 1);
  endfunction

endpackage

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - programmable serial pattern matcher with fill tracking and overlap control
module pattern_match_core
  import pattern_scan_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LEN_W   = len_w(PAT_MAX_DEF)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               match
);

  logic [PAT_MAX-1:0] hist_q;
  logic [PAT_MAX-1:0] hist_d;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_d;
  logic [PAT_MAX-1:0] len_mask;
  logic               hit;
  logic               match_q;
  logic               match_d;

  // Next history/fill and the masked compare that includes the incoming bit
  always_comb begin
    hist_d   = (hist_q << 1) | PAT_MAX'(bit_in);
    fill_inc = (fill_q >= LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : fill_q + LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      len_mask[i] = (i < int'(len));
    end
    hit     = (fill_inc >= len) && (((hist_d ^ pattern) & len_mask) == '0);
    fill_d  = (hit && !overlap) ? '0 : fill_inc;
    match_d = bit_valid && hit;
  end

  // History, fill and registered match; clear wipes all state at frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else if (clear) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
      if (bit_valid) begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
    end
  end

  assign match = match_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - frame controller: word handshake, MSB-first serialization, match counting
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W  = WORD_W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [PAT_MAX-1:0]          cfg_pattern,
  input  logic [len_w(PAT_MAX)-1:0]   cfg_len,
  input  logic                        cfg_overlap,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        match,
  output logic [CNT_W-1:0]            match_count,
  output logic                        done,
  output logic                        err
);

  localparam int LEN_W  = len_w(PAT_MAX);
  localparam int BCNT_W = $clog2(WORD_W + 1);

  scan_state_e        state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [BCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               rej_q, rej_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               cfg_ok;
  logic               core_clear;
  logic               bit_valid;
  logic               core_match;

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      last_q   <= 1'b0;
      bitcnt_q <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      rej_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      last_q   <= last_d;
      bitcnt_q <= bitcnt_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      rej_q    <= rej_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, datapath updates and handshake/status outputs
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    bitcnt_d   = bitcnt_q;
    pat_d      = pat_q;
    len_d      = len_q;
    ovl_d      = ovl_q;
    rej_d      = rej_q;
    cnt_d      = cnt_q;
    core_clear = 1'b0;
    bit_valid  = 1'b0;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    // The registered match trails the shift by one edge, so the count catches up one cycle later
    if (core_match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (cfg_ok) begin
            pat_d      = cfg_pattern;
            len_d      = cfg_len;
            ovl_d      = cfg_overlap;
            rej_d      = 1'b0;
            core_clear = 1'b1;
            state_d    = ST_ACCEPT;
          end else begin
            rej_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          word_d   = in_data;
          last_d   = in_last;
          bitcnt_d = BCNT_W'(WORD_W);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        word_d    = word_q << 1;
        bitcnt_d  = bitcnt_q - BCNT_W'(1);
        if (bitcnt_q == BCNT_W'(1)) begin
          state_d = last_q ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_DONE: begin
        busy    = !rej_q;
        done    = 1'b1;
        err     = rej_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  pattern_match_core #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (core_clear),
    .bit_valid (bit_valid),
    .bit_in    (word_q[WORD_W-1]),
    .pattern   (pat_q),
    .len       (len_q),
    .overlap   (ovl_q),
    .match     (core_match)
  );

  assign match       = core_match;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - scoreboard bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       match;
  logic [7:0] match_count;
  logic       done;
  logic       err;

  int n_chk;
  int n_fail;
  int cyc;

  typedef struct {
    int cyc;
    bit err;
  } done_t;

  int    exp_match_q[$];
  done_t exp_done_q[$];

  logic [7:0] m_hist;
  logic [7:0] m_pat;
  int         m_len;
  int         m_fill;
  bit         m_ovl;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .busy        (busy),
    .match       (match),
    .match_count (match_count),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(input logic [7:0] p, input int l, input bit o);
    m_hist = '0;
    m_fill = 0;
    m_pat  = p;
    m_len  = l;
    m_ovl  = o;
  endtask

  task automatic model_bit(input bit b, input int c);
    bit hit;
    m_hist = {m_hist[6:0], b};
    if (m_fill < 8) m_fill++;
    hit = (m_fill >= m_len);
    for (int i = 0; i < m_len; i++) begin
      if (m_hist[i] != m_pat[i]) hit = 0;
    end
    if (hit) begin
      exp_match_q.push_back(c);
      if (!m_ovl) m_fill = 0;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (match) begin
        if (exp_match_q.size() == 0) check("match_extra", cyc, -1);
        else check("match_cyc", cyc, exp_match_q.pop_front());
      end
      if (done) begin
        if (exp_done_q.size() == 0) check("done_extra", cyc, -1);
        else begin
          done_t d;
          d = exp_done_q.pop_front();
          check("done_cyc", cyc, d.cyc);
          check("done_err", err, d.err);
        end
      end else if (err) begin
        check("err_stray", err, 0);
      end
    end
  end

  task automatic start_frame(input logic [7:0] p, input logic [3:0] l, input bit o, output int t);
    start       = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    @(posedge clk);
    #1;
    t     = cyc;
    start = 1'b0;
    model_reset(p, int'(l), o);
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, input bit hold, input int nb, output int a);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) break;
      @(posedge clk);
      #1;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    a = cyc;
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    for (int k = 1; k <= nb; k++) model_bit(d[8-k], a + k);
    if (l && nb == 8) exp_done_q.push_back('{cyc: a + 8, err: 1'b0});
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_match_q.size() == 0 && exp_done_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (i == 400) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic finish_frame(input string tag, input int exp_cnt);
    drain(tag);
    @(posedge clk);
    #1;
    check({tag, "_count"}, match_count, exp_cnt);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int t;
    int a;
    n_chk       = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_match", match, 0);
    check("rst_count", match_count, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // overlapping 1101 over 0xDB
    start_frame(8'h0D, 4'd4, 1'b1, t);
    check("t1_busy", busy, 1);
    check("t1_ready", in_ready, 1);
    send_word(8'hDB, 1'b1, 1'b0, 8, a);
    finish_frame("t1", 2);

    // non-overlapping, same stimulus
    start_frame(8'h0D, 4'd4, 1'b0, t);
    send_word(8'hDB, 1'b1, 1'b0, 8, a);
    finish_frame("t2", 1);

    // history carried across the word boundary
    start_frame(8'h0D, 4'd4, 1'b1, t);
    send_word(8'h01, 1'b0, 1'b0, 8, a);
    send_word(8'hA0, 1'b1, 1'b0, 8, a);
    check("t3_pending", exp_match_q.size(), 1);
    finish_frame("t3", 1);

    // saturation of the match counter
    start_frame(8'h01, 4'd1, 1'b1, t);
    for (int w = 0; w < 32; w++) send_word(8'hFF, (w == 31), 1'b0, 8, a);
    finish_frame("t4", 255);

    // rejected starts: length 0 and length above the maximum
    start_frame(8'h0D, 4'd0, 1'b1, t);
    exp_done_q.push_back('{cyc: t, err: 1'b1});
    check("t5_busy", busy, 0);
    check("t5_ready", in_ready, 0);
    finish_frame("t5", 0);
    start_frame(8'h0D, 4'd9, 1'b1, t);
    exp_done_q.push_back('{cyc: t, err: 1'b1});
    check("t5b_busy", busy, 0);
    finish_frame("t5b", 0);

    // reset in the middle of a word with in_valid held high
    start_frame(8'h01, 4'd1, 1'b1, t);
    send_word(8'hFF, 1'b0, 1'b1, 3, a);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t6_ready_shift", in_ready, 0);
    end
    check("t6_count_pre", match_count, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_ready", in_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_match", match, 0);
    check("t6_rst_count", match_count, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", err, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_idle_busy", busy, 0);
    check("t6_idle_ready", in_ready, 0);
    start_frame(8'h0D, 4'd4, 1'b1, t);
    send_word(8'hDB, 1'b1, 1'b0, 8, a);
    finish_frame("t6_new", 2);

    repeat (3) @(posedge clk);
    #1;
    check("left_matches", exp_match_q.size(), 0);
    check("left_dones", exp_done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

- Frame-level controller for the team's serial pattern detectors.
- Accepts a frame of words over a valid/ready stream, serializes each word MSB-first into a programmable pattern matcher, counts matches, and signals frame completion.
- Pattern, length and overlap mode are programmable per frame; the matcher replaces a hard-wired per-pattern FSM.

## Interface
Parameters:
- WORD_W, default 8: input word width, bits serialized per word.
- PAT_MAX, default 8: maximum pattern length in bits.
- CNT_W, default 8: match counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin frame; sampled only in IDLE.
- cfg_pattern  input  PAT_MAX  pattern; bit 0 = most recent bit; latched on accepted start.
- cfg_len  input  $clog2(PAT_MAX+1)  pattern length; valid range 1..PAT_MAX; latched on start.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping; latched on start.
- in_valid  input  1  word available.
- in_data  input  WORD_W  word; in_data[WORD_W-1] is shifted first.
- in_last  input  1  qualifies in_data as the final word of the frame.
- in_ready  output  1  controller accepts a word this cycle.
- busy  output  1  frame in progress.
- match  output  1  one-cycle pulse per detected match.
- match_count  output  CNT_W  saturating match count for the current/last frame.
- done  output  1  one-cycle pulse at frame end.
- err  output  1  one-cycle pulse, coincident with done, on rejected start.

## Operation
- All outputs reset to 0. Reset forces IDLE, clears history, fill counter and match_count.
- FSM states: IDLE, ACCEPT, SHIFT, DONE.
- IDLE: on start with 1 <= cfg_len <= PAT_MAX:
  - latch cfg_*;
  - clear history, fill counter and match_count;
  - go to ACCEPT.
- IDLE, invalid cfg_len (0 or > PAT_MAX): clear match_count, go to DONE with err set.
- ACCEPT: in_ready=1. On in_valid: capture in_data and in_last, load bit counter = WORD_W, go to SHIFT.
- SHIFT: each cycle
  - shift the next bit into the history LSB; increment fill, saturating at PAT_MAX;
  - decrement the bit counter.
- After WORD_W bits: go to DONE if the captured in_last was 1, else back to ACCEPT.
- Match condition, evaluated on each shifted bit: fill (including this bit) >= len and history[len-1:0] == pattern[len-1:0].
- On match:
  - match pulses;
  - match_count increments, saturating at 2^CNT_W-1;
  - if non-overlapping, fill clears to 0 so the next match needs len fresh bits.
- Overlapping mode leaves fill unchanged after a match.
- History and fill persist across word boundaries within a frame. They never persist across frames.
- DONE: done=1 (and err=1 if rejected) for one cycle, then go to IDLE.
- start is ignored outside IDLE. match_count holds after done until the next accepted start.
- reset_n asserted mid-frame aborts the frame: no done, and the word in flight is discarded.

## Timing
- start sampled at edge t: busy=1 and in_ready=1 from t+1.
- busy stays high through the DONE cycle. For a rejected start, busy stays 0.
- Word accepted at edge a: bits shift at edges a+1..a+WORD_W.
- The match for the bit shifted at edge a+k is visible in the cycle after that edge.
- in_ready is low during SHIFT and DONE. Throughput is one word per WORD_W+1 cycles.
- Last word: edge a+WORD_W enters DONE. done and the final bit's match are both high in that cycle; busy falls at the next edge.
- Rejected start at edge t: done=err=1 in cycle t+1.

## Structure
- Package pattern_scan_pkg holds:
  - the state enum typedef (IDLE, ACCEPT, SHIFT, DONE);
  - default WORD_W/PAT_MAX/CNT_W constants;
  - a len-width localparam function.
- Sub-module pattern_match_core: history register, fill counter, masked compare and overlap clear. Inputs: bit_valid, bit_in, clear, latched cfg. Output: registered match.
- The controller owns the FSM, word buffer, bit counter, handshake and match_count.

## Test plan
- Pattern 4'b1101, len 4, overlap=1, single word 0xDB with in_last -> 2 match pulses, match_count=2, done 9 cycles after the accept edge.
- Same stimulus with overlap=0 -> exactly 1 match (on bit 3), match_count=1.
- Pattern 1101, len 4, words 0x01 then 0xA0 (in_last on 2nd) -> 1 match, on the 3rd bit of word 1 (cross-boundary history).
- Pattern 1'b1, len 1, overlap=1, 32 words of 0xFF -> match_count saturates at 255; done pulses once.
- start with cfg_len=0 -> done=err=1 next cycle, busy never high, match_count=0.
- in_valid held high through SHIFT, then reset_n pulsed low mid-SHIFT:
  - before reset: in_ready=0 during SHIFT and no word accepted twice;
  - during reset: all outputs 0 immediately;
  - after release: IDLE, and a new frame counts from 0.
